vt57_row_fetch: RTL and testbench
=================================

# vt57_row_fetch

DMA-style character-row fetcher that sits directly upstream of the display controller, in the role the KR580VT57 channel 2 plays in a Radio-86RK. Once per character row it reads `COLS` bytes of screen memory through a request/acknowledge port into one half of a double-buffered line buffer. The display side reads the other half with one-cycle latency. Base address, byte count and channel enable are CPU-programmable at the VT57 port addresses.

## Interface
Parameters:
- `COLS`, 80: bytes fetched per character row
- `CW`, 7: width of the column index

Ports:
- `clock`  in  1  system clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `cpu_address`  in  16  CPU bus address
- `cpu_out`  in  8  CPU write data
- `cpu_we`  in  1  CPU write strobe, one cycle per write
- `frame_start`  in  1  one-cycle pulse: reload the fetch pointer for a new frame
- `row_start`  in  1  one-cycle pulse: swap banks and fetch the next row
- `mem_address`  out  16  memory read address
- `mem_req`  out  1  memory read request
- `mem_ack`  in  1  memory acknowledge; `mem_in` is valid in this cycle
- `mem_in`  in  8  memory read data
- `disp_col`  in  CW  display read column
- `disp_data`  out  8  registered buffer byte for `disp_col`
- `busy`  out  1  a fill is in progress
- `underrun`  out  1  sticky: `row_start` arrived while busy

## Operation
- **CPU registers** (written only when `cpu_we`=1):
  - E004: channel-2 address. The first write sets the low byte, the second write sets the high byte.
  - E005: channel-2 count. Same low/high sequencing. Only bits [13:0] are kept; bits [15:14] are ignored.
  - E004 and E005 share one byte-select flip-flop, which toggles on every write to either address.
  - E008: mode register. Bit 2 enables the channel. Any write to E008 clears the flip-flop and clears `underrun`.
- **Reset values of registers:** base = E6A0, count = 095F (so COUNT+1 = 2400 = 80×30 bytes), enable = 1, flip-flop = 0.
- **Live pointers:** `ptr` (16 bits) and `remaining` (15 bits). They are loaded only on `frame_start`: `ptr` ← base, `remaining` ← count+1. CPU writes made mid-frame take effect at the next `frame_start`.
- **Line buffer:** 2×`COLS` bytes. `wbank` is the bank being filled; the display reads `!wbank`. Buffer contents are not reset.
- **State machine** — states IDLE, FETCH, ZERO:
  - IDLE + `row_start`, not busy: toggle `wbank` and set col = 0. Go to FETCH if enable=1 and `remaining`>0; otherwise go to ZERO.
  - FETCH: `mem_req`=1 and `mem_address`=`ptr`. In each cycle where `mem_ack`=1:
    - write `mem_in` to buf[wbank][col];
    - `ptr`++ (wraps FFFF→0000), `remaining`--, col++.
    - If col was COLS−1, go to IDLE.
    - Else if `remaining` becomes 0, go to ZERO.
    - Otherwise `mem_req` stays high and `mem_address` shows the new `ptr` in the next cycle.
  - ZERO: write 00 to buf[wbank][col], one byte per cycle. After col = COLS−1, go to IDLE. No memory requests are made in this state.
  - `busy` = (state ≠ IDLE).
- **Boundary cases:**
  - `frame_start` and `row_start` in the same cycle: the reload happens first, then the row fetch starts from the new base.
  - `frame_start` while busy: abort. Go to IDLE; `mem_req` is low from the next cycle. Reload the pointers. `wbank` is unchanged.
  - `row_start` while busy (and no `frame_start`): ignore it and set `underrun`=1.
  - `mem_ack` while `mem_req`=0: ignored.
  - `disp_col` ≥ COLS: `disp_data` ← 00.
  - `reset_n` low mid-fetch: all state returns to its reset values immediately; `mem_req` drops asynchronously.

## Timing
- **Reset values of outputs:** `mem_req` 0, `mem_address` 0000, `busy` 0, `underrun` 0, `disp_data` 00. `wbank` resets to 0.
- **Fill start:** with `row_start` high in cycle N, `mem_req` and `busy` are high in cycle N+1, with `mem_address` = `ptr`.
- **Fill duration:** with zero-wait `mem_ack`, a full row fetch takes COLS cycles; `busy` falls in cycle N+COLS+1. A ZERO fill also takes COLS cycles.
- **Display read:** `disp_data` is registered, so the byte for `disp_col` sampled in cycle N appears in N+1. A bank swap is visible to the display in the cycle after `row_start`.
- **CPU writes:** one write per cycle at most; each takes effect in the cycle after it.

## Test plan
- **Reset defaults:** reset, then pulse `frame_start` and `row_start`; ack every request. Expect addresses E6A0…E6EF. After the next `row_start`, `disp_col`=0 returns memory[E6A0] one cycle later.
- **Reprogramming:** write E008=04, E004=00, E004=70, E005=4F, E005=00, then `frame_start` + `row_start`. Expect 80 reads at 7000…704F. On the next `row_start`, `remaining`=0, so no `mem_req` and bank filled with 00.
- **Short count:** count = 0009, then `frame_start` + `row_start`. Expect 10 reads, then buf cols 10…79 = 00, with `busy` high for 80 ack cycles total.
- **Wait states:** hold `mem_ack` low for 3 cycles per byte. Expect `mem_address` stable while `mem_req` is high, and no skipped or duplicated bytes.
- **Overlap:** `row_start` while busy sets `underrun`=1 and the fetch continues; a write to E008 clears it. `frame_start` mid-fetch drops `mem_req` the next cycle and restarts from base on the next `row_start`.
- **Async reset:** assert `reset_n`=0 mid-fetch. `mem_req`, `busy`, `underrun` and `disp_data` go to 0 before the next clock edge, and register reads after release show the reset defaults.

Source files
------------

// File: rtl/vt57_row_fetch.sv
// Character-row DMA fetcher: fills one half of a double-buffered line buffer
// from screen memory each row while the display reads the other half.
`timescale 1ns/1ps
module vt57_row_fetch #(
  parameter int COLS = 80,
  parameter int CW   = 7
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [15:0]   cpu_address,
  input  logic [7:0]    cpu_out,
  input  logic          cpu_we,
  input  logic          frame_start,
  input  logic          row_start,
  output logic [15:0]   mem_address,
  output logic          mem_req,
  input  logic          mem_ack,
  input  logic [7:0]    mem_in,
  input  logic [CW-1:0] disp_col,
  output logic [7:0]    disp_data,
  output logic          busy,
  output logic          underrun
);

  localparam int CW1 = CW + 1;
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [CW:0]   COLS_W   = CW1'(COLS);

  typedef enum logic [1:0] {IDLE, FETCH, ZERO} state_e;

  state_e        state_q, state_d;
  logic [15:0]   base_q, base_d;
  logic [13:0]   cnt_q, cnt_d;
  logic          en_q, en_d;
  logic          ff_q, ff_d;
  logic          und_q, und_d;
  logic          wbank_q, wbank_d;
  logic [15:0]   ptr_q, ptr_d;
  logic [14:0]   rem_q, rem_d;
  logic [CW-1:0] col_q, col_d;
  logic [7:0]    disp_q;

  logic [7:0]    line_q [2*COLS];
  logic          lb_we;
  logic [7:0]    lb_wdata;
  logic [CW:0]   lb_waddr, lb_raddr;

  logic          wr_addr, wr_cnt, wr_mode;
  logic [14:0]   reload_rem, rem_eff;
  logic          can_start;

  assign wr_addr = cpu_we && (cpu_address == 16'hE004);
  assign wr_cnt  = cpu_we && (cpu_address == 16'hE005);
  assign wr_mode = cpu_we && (cpu_address == 16'hE008);

  // E004/E005 share a single low/high byte toggle, as on the original part
  always_comb begin
    base_d = base_q;
    cnt_d  = cnt_q;
    en_d   = en_q;
    ff_d   = ff_q;
    if (wr_addr) begin
      if (ff_q) base_d[15:8] = cpu_out;
      else      base_d[7:0]  = cpu_out;
      ff_d = !ff_q;
    end
    if (wr_cnt) begin
      if (ff_q) cnt_d[13:8] = cpu_out[5:0];
      else      cnt_d[7:0]  = cpu_out;
      ff_d = !ff_q;
    end
    if (wr_mode) begin
      en_d = cpu_out[2];
      ff_d = 1'b0;
    end
  end

  assign reload_rem = {1'b0, cnt_q} + 15'd1;
  assign rem_eff    = frame_start ? reload_rem : rem_q;
  // a frame_start in the same cycle aborts any fill, so the row may start at once
  assign can_start  = (state_q == IDLE) || frame_start;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    col_d    = col_q;
    wbank_d  = wbank_q;
    und_d    = und_q;
    lb_we    = 1'b0;
    lb_wdata = 8'h00;

    if (wr_mode) und_d = 1'b0;

    if (frame_start) begin
      ptr_d   = base_q;
      rem_d   = reload_rem;
      state_d = IDLE;
    end

    if (row_start && can_start) begin
      wbank_d = !wbank_q;
      col_d   = '0;
      state_d = (en_q && (rem_eff != 15'd0)) ? FETCH : ZERO;
    end else if (row_start) begin
      und_d = 1'b1;
    end

    if (!frame_start) begin
      unique case (state_q)
        FETCH: begin
          if (mem_ack) begin
            lb_we    = 1'b1;
            lb_wdata = mem_in;
            ptr_d    = ptr_q + 16'd1;
            rem_d    = rem_q - 15'd1;
            col_d    = col_q + 1'b1;
            if (col_q == LAST_COL)    state_d = IDLE;
            else if (rem_q == 15'd1)  state_d = ZERO;
          end
        end
        ZERO: begin
          lb_we = 1'b1;
          col_d = col_q + 1'b1;
          if (col_q == LAST_COL) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      base_q  <= 16'hE6A0;
      cnt_q   <= 14'h095F;
      en_q    <= 1'b1;
      ff_q    <= 1'b0;
      und_q   <= 1'b0;
      wbank_q <= 1'b0;
      ptr_q   <= 16'h0000;
      rem_q   <= 15'd0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      ff_q    <= ff_d;
      und_q   <= und_d;
      wbank_q <= wbank_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      col_q   <= col_d;
    end
  end

  // bank 1 occupies the upper COLS entries of the buffer
  assign lb_waddr = wbank_q  ? (COLS_W + {1'b0, col_q})    : {1'b0, col_q};
  assign lb_raddr = !wbank_q ? (COLS_W + {1'b0, disp_col}) : {1'b0, disp_col};

  always_ff @(posedge clock) begin
    if (lb_we) line_q[lb_waddr] <= lb_wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                       disp_q <= 8'h00;
    else if ({1'b0, disp_col} < COLS_W) disp_q <= line_q[lb_raddr];
    else                                disp_q <= 8'h00;
  end

  assign mem_req     = (state_q == FETCH);
  assign mem_address = ptr_q;
  assign busy        = (state_q != IDLE);
  assign underrun    = und_q;
  assign disp_data   = disp_q;

endmodule

// File: tb/tb_vt57_row_fetch.sv
// Scoreboard bench for vt57_row_fetch: stimulus queues expected addresses and
// display bytes, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_vt57_row_fetch;
  localparam int COLS = 80;
  localparam int CW   = 7;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [15:0]   cpu_address = 16'h0;
  logic [7:0]    cpu_out = 8'h0;
  logic          cpu_we = 1'b0;
  logic          frame_start = 1'b0;
  logic          row_start = 1'b0;
  logic [15:0]   mem_address;
  logic          mem_req;
  logic          mem_ack;
  logic [7:0]    mem_in;
  logic [CW-1:0] disp_col = '0;
  logic [7:0]    disp_data;
  logic          busy;
  logic          underrun;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  dq[$];

  logic ack_on = 1'b1, ack_force = 1'b0, rd_req = 1'b0, rd_vld = 1'b0;
  int   wait_n = 0, wait_cnt = 0;

  vt57_row_fetch #(.COLS(COLS), .CW(CW)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we),
    .frame_start(frame_start), .row_start(row_start),
    .mem_address(mem_address), .mem_req(mem_req), .mem_ack(mem_ack), .mem_in(mem_in),
    .disp_col(disp_col), .disp_data(disp_data), .busy(busy), .underrun(underrun)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] mdata(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  assign mem_in  = mdata(mem_address);
  assign mem_ack = ack_force | (mem_req & ack_on & (wait_cnt >= wait_n));

  always @(posedge clock) begin
    wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
    rd_vld   <= rd_req;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // monitor: memory handshakes and display bytes
  always @(negedge clock) begin
    if (reset_n && mem_req) begin
      if (exp_q.size() != 0) chk("mem_address", {16'h0, mem_address}, {16'h0, exp_q[0]});
      if (mem_ack) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ack got addr=%h required=none", mem_address);
        end else void'(exp_q.pop_front());
      end
    end
    if (rd_vld) begin
      if (dq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_disp got=%h required=none", disp_data);
      end else chk("disp_data", {24'h0, disp_data}, {24'h0, dq.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_address = a; cpu_out = d; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic pulse(input logic f, input logic r);
    frame_start = f; row_start = r;
    tick();
    frame_start = 1'b0; row_start = 1'b0;
  endtask

  task automatic rd(input logic [CW-1:0] c, input logic [7:0] e);
    disp_col = c; dq.push_back(e); rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic push_rng(input logic [15:0] b, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(b + 16'(i));
  endtask

  task automatic wait_idle(input int exp_n, input string nm);
    int n = 0;
    while (busy && n < 400) begin n++; tick(); end
    chk(nm, n, exp_n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_mem_req", {31'h0, mem_req}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_underrun", {31'h0, underrun}, 0);
    chk("rst_disp_data", {24'h0, disp_data}, 0);
    chk("rst_mem_address", {16'h0, mem_address}, 0);
    reset_n = 1'b1;
    tick();

    // reset defaults: base E6A0, 80 bytes per row
    push_rng(16'hE6A0, 80);
    pulse(1, 1);
    chk("start_req", {31'h0, mem_req}, 1);
    chk("start_busy", {31'h0, busy}, 1);
    chk("start_addr", {16'h0, mem_address}, 32'hE6A0);
    wait_idle(80, "t1_busy_cycles");
    ack_force = 1'b1; tick(); tick(); ack_force = 1'b0;
    push_rng(16'hE6F0, 80);
    pulse(0, 1);
    rd(0, 8'h46); rd(79, 8'h09); rd(80, 8'h00); rd(127, 8'h00);
    wait_idle(76, "t1_row2_cycles");
    chk("t1_underrun", {31'h0, underrun}, 0);

    // reprogramming: base 7000, count 004F
    wr(16'hE008, 8'h04); wr(16'hE004, 8'h00); wr(16'hE004, 8'h70);
    wr(16'hE005, 8'h4F); wr(16'hE005, 8'h00);
    push_rng(16'h7000, 80);
    pulse(1, 1);
    wait_idle(80, "t2_fetch_cycles");
    pulse(0, 1);
    chk("t2_zero_req", {31'h0, mem_req}, 0);
    chk("t2_zero_busy", {31'h0, busy}, 1);
    rd(5, 8'h75);
    wait_idle(79, "t2_zero_cycles");

    // short count: 10 bytes then zero fill
    wr(16'hE005, 8'h09); wr(16'hE005, 8'h00);
    push_rng(16'h7000, 10);
    pulse(1, 1);
    rd(3, 8'h00);
    wait_idle(79, "t3_short_cycles");
    pulse(0, 1);
    rd(9, 8'h79); rd(10, 8'h00); rd(0, 8'h70);
    wait_idle(77, "t3_zero_cycles");

    // wait states: 3 idle cycles before every ack
    wr(16'hE004, 8'h34); wr(16'hE004, 8'h12);
    wr(16'hE005, 8'h07); wr(16'hE005, 8'h00);
    wait_n = 3;
    push_rng(16'h1234, 8);
    pulse(1, 1);
    wait_idle(104, "t4_wait_cycles");
    wait_n = 0;
    pulse(0, 1);
    rd(0, 8'h26); rd(7, 8'h29); rd(8, 8'h00);
    wait_idle(77, "t4_zero_cycles");

    // overlap: row_start while busy, then abort by frame_start
    wr(16'hE005, 8'h4F); wr(16'hE005, 8'h00);
    push_rng(16'h1234, 80);
    pulse(1, 1);
    repeat (10) tick();
    pulse(0, 1);
    chk("t5_underrun_set", {31'h0, underrun}, 1);
    wait_idle(69, "t5_fetch_cycles");
    chk("t5_underrun_sticky", {31'h0, underrun}, 1);
    wr(16'hE008, 8'h04);
    chk("t5_underrun_clr", {31'h0, underrun}, 0);
    push_rng(16'h1234, 5);
    pulse(1, 1);
    repeat (5) tick();
    ack_on = 1'b0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0; ack_on = 1'b1;
    chk("t5_abort_req", {31'h0, mem_req}, 0);
    chk("t5_abort_busy", {31'h0, busy}, 0);
    chk("t5_abort_ptr", {16'h0, mem_address}, 32'h1234);
    push_rng(16'h1234, 80);
    pulse(0, 1);
    wait_idle(80, "t5_restart_cycles");

    // async reset mid-fetch
    push_rng(16'h1234, 80);
    pulse(1, 1);
    rd(0, 8'h26);
    repeat (3) tick();
    pulse(0, 1);
    chk("t6_underrun_pre", {31'h0, underrun}, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_req", {31'h0, mem_req}, 0);
    chk("t6_rst_busy", {31'h0, busy}, 0);
    chk("t6_rst_underrun", {31'h0, underrun}, 0);
    chk("t6_rst_disp", {24'h0, disp_data}, 0);
    chk("t6_rst_addr", {16'h0, mem_address}, 0);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    tick();
    push_rng(16'hE6A0, 80);
    pulse(1, 1);
    wait_idle(80, "t6_default_cycles");

    tick();
    chk("addr_q_drained", exp_q.size(), 0);
    chk("disp_q_drained", dq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
